store_unit: RTL

Write-side counterpart of the load data formatter. Accepts SW/SH/SB requests from the MEM stage and converts each into a word-aligned address, 4-bit byte strobe and lane-replicated write data. Buffers the formatted stores in a small FIFO. Drains them one at a time to the data memory over a req/addr_ok/data_ok handshake, and reports when the buffer is empty so later loads can be ordered behind pending stores.

---
 rtl/store_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// store_unit
//   Write-side counterpart of the load data formatter. MEM-stage SW/SH/SB
//   requests are turned into a word address, a 4-bit byte strobe and
//   lane-replicated write data, queued in a small store buffer and drained
//   one at a time to data memory over a req/addr_ok/data_ok handshake.
//
// Parameters
//   DEPTH         store buffer entries (power of two, >= 2)
//
// Optional feature macro
//   STORE_ALIGN_EXC_EN  when defined, misaligned SH/SW raise adesM and are
//                       dropped; when undefined adesM/badvaddrM are tied low
//                       and misaligned stores are pushed with the low address
//                       bits ignored (SW) or only addr[1] honoured (SH).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   st_valid                  MEM stage presents an operation
//   alucontrolM[7:0]          operation code (SW/SH/SB acted on)
//   addrM[31:0]               effective byte address
//   writedataM[31:0]          store source value
//   st_ready                  buffer can accept a store (registered count only)
//   adesM, badvaddrM[31:0]    store address error and faulting address
//   sb_empty                  nothing buffered and no write in flight
//   data_req                  write request to data memory
//   data_addr/wstrb/wdata     head entry while a write is in progress, else 0
//   data_addr_ok, data_data_ok  memory handshake responses

module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic        st_ready,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  output logic        sb_empty,
  output logic        data_req,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [7:0] EXE_SB_OP = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP = 8'b11101011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic [29:0]     buf_addr  [DEPTH];
  logic [3:0]      buf_wstrb [DEPTH];
  logic [31:0]     buf_wdata [DEPTH];

  logic            is_sb;
  logic            is_sh;
  logic            is_sw;
  logic            is_store;
  logic [3:0]      fmt_wstrb;
  logic [31:0]     fmt_wdata;
  logic            push;
  logic            pop;
  logic            active;

  assign is_sb    = (alucontrolM == EXE_SB_OP);
  assign is_sh    = (alucontrolM == EXE_SH_OP);
  assign is_sw    = (alucontrolM == EXE_SW_OP);
  assign is_store = is_sb | is_sh | is_sw;

  // Byte strobe and lane replication for the incoming store. Replicating
  // the source into every lane lets memory pick the lane purely by strobe.
  always_comb begin
    fmt_wstrb = 4'b0000;
    fmt_wdata = 32'h0;
    if (is_sw) begin
      fmt_wstrb = 4'b1111;
      fmt_wdata = writedataM;
    end else if (is_sh) begin
      fmt_wstrb = addrM[1] ? 4'b1100 : 4'b0011;
      fmt_wdata = {2{writedataM[15:0]}};
    end else if (is_sb) begin
      fmt_wstrb = 4'b0001 << addrM[1:0];
      fmt_wdata = {4{writedataM[7:0]}};
    end
  end

`ifdef STORE_ALIGN_EXC_EN
  logic misaligned;
  assign misaligned = (is_sh & addrM[0]) | (is_sw & (addrM[1:0] != 2'b00));
  assign adesM      = st_valid & misaligned;
  assign badvaddrM  = adesM ? addrM : 32'h0;
`else
  assign adesM      = 1'b0;
  assign badvaddrM  = 32'h0;
`endif

  // st_ready depends only on the registered count, so a same-cycle pop
  // never frees a slot for a push on a full buffer.
  assign st_ready = (count != FULL_COUNT);
  assign push     = st_valid & st_ready & is_store & ~adesM;

  // Buffer storage: data only, so it needs no reset; validity is tracked
  // by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail]  <= addrM[31:2];
      buf_wstrb[tail] <= fmt_wstrb;
      buf_wdata[tail] <= fmt_wdata;
    end
  end

  // Drain FSM next-state and handshake decode. Only one write is ever
  // outstanding; the entry pops when data_ok completes it.
  always_comb begin
    state_nx = state;
    data_req = 1'b0;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) state_nx = S_REQ;
      end
      S_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          pop      = 1'b1;
          state_nx = S_IDLE;
        end else if (data_addr_ok) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          pop      = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, pointers and occupancy count. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nx;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head is only presented while a write is in progress; it cannot
  // change during REQ because it moves only on pop.
  assign active     = (state != S_IDLE);
  assign data_addr  = active ? {buf_addr[head], 2'b00} : 32'h0;
  assign data_wstrb = active ? buf_wstrb[head] : 4'b0000;
  assign data_wdata = active ? buf_wdata[head] : 32'h0;

  assign sb_empty = (count == '0) && (state == S_IDLE);

endmodule
